// File: rtl/nibble_serial_subtractor_if.sv
// Operand and result valid/ready port bundle for nibble_serial_subtractor.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out, ovf
  );

  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out, ovf
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: diff = a - b - b_in, one 4-bit borrow-lookahead slice per clock.
// Define SUB_SIGNED_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst,
  nibble_serial_subtractor_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             bw_q;
  logic [WIDTH-1:0] diff_q;
  logic             b_out_q;

  logic             accept;
  logic             step;
  logic             last;
  logic [3:0]       a_s;
  logic [3:0]       b_s;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [4:0]       bw;
  logic [3:0]       d;
  logic [WIDTH-1:0] res_n;

  assign accept = (state == IDLE) && bus.in_valid;
  assign step   = (state == BUSY);
  assign last   = step && (cnt == CW'(NIB - 1));

  // Operands shift right by a nibble each step, so the active slice is always [3:0].
  assign a_s = a_q[3:0];
  assign b_s = b_q[3:0];

  always_comb begin
    g     = ~a_s & b_s;
    p     = ~(a_s ^ b_s);
    bw    = '0;
    bw[0] = bw_q;
    bw[1] = g[0] | (p[0] & bw[0]);
    bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bw[0]);
    bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & bw[0]);
    bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bw[0]);
    d     = a_s ^ b_s ^ bw[3:0];
  end

  // New slice enters at the top; after NIB steps slice k sits at bits [4k+3:4k].
  assign res_n = WIDTH'({d, res_q} >> 4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.in_valid) state_n = BUSY;
      BUSY: if (last) state_n = DONE;
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bw_q    <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      a_q   <= bus.a;
      b_q   <= bus.b;
      res_q <= '0;
      bw_q  <= bus.b_in;
    end else if (step) begin
      cnt   <= cnt + CW'(1);
      a_q   <= a_q >> 4;
      b_q   <= b_q >> 4;
      res_q <= res_n;
      bw_q  <= bw[4];
      if (last) begin
        diff_q  <= res_n;
        b_out_q <= bw[4];
      end
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // Sign bits are kept aside because the operand registers are shifted away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (last) begin
      ovf_q <= (a_msb != b_msb) & (res_n[WIDTH-1] != a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_q;
  assign bus.b_out     = b_out_q;

endmodule
